n_bit_serial_sub: RTL and testbench

- Sequential, bit-serial N-bit subtractor computing `a - b - bin`, one bit per clock, LSB first.
- Inverse-direction companion to the parallel N-bit ripple adder: same operand widths and same carry/borrow-in convention.
- Trades the adder's combinational chain for a single one-bit cell plus shift registers.
- Sits behind a start/done handshake, so a controller can issue subtracts and collect difference, borrow and signed-overflow results.

---
 rtl/n_bit_pkg.sv | 14 +
 rtl/full_subtractor.sv | 19 +
 rtl/n_bit_serial_sub.sv | 120 ++++++++++++
 tb/tb_n_bit_serial_sub.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/n_bit_pkg.sv
// Shared definitions for the bit-serial subtractor.
// Holds the FSM state encoding and the default operand width so the
// top level and any controller that talks to it agree on both.
package n_bit_pkg;

  localparam int N_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: computes x - y - bi.
// Ports:
//   x, y : operand bits (minuend, subtrahend)
//   bi   : borrow in
//   d    : difference bit
//   bo   : borrow out
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  // A borrow leaves the cell when x=0,y=1, or when x==y and a borrow came in.
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/n_bit_serial_sub.sv
// Bit-serial N-bit subtractor: diff = (a - b - bin) mod 2^N, LSB first,
// one bit per clock, behind a start/done handshake.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   start        : request, only sampled while idle
//   a, b, bin    : minuend, subtrahend, borrow-in (captured on accept)
//   busy         : high while bits are being processed
//   done         : one-cycle pulse when diff/bout/ovf are fresh
//   diff         : registered difference
//   bout         : registered unsigned borrow out
//   ovf          : registered two's-complement overflow
module n_bit_serial_sub
  import n_bit_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         ovf
);

  localparam int CW = $clog2(N);

  state_e          state_q, state_d;
  logic [N-1:0]    sa_q, sb_q, w_q;
  logic            br_q;
  logic [CW-1:0]   cnt_q;
  logic            aMsb_q, bMsb_q;
  logic [N-1:0]    diff_q;
  logic            bout_q, ovf_q;

  logic            bitD, bitBo, lastBit;

  full_subtractor uCell (
    .x  (sa_q[0]),
    .y  (sb_q[0]),
    .bi (br_q),
    .d  (bitD),
    .bo (bitBo)
  );

  assign lastBit = (cnt_q == CW'(N - 1));

  // Next-state logic: RUN lasts exactly N cycles, DONE exactly one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (lastBit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and state register. The operand registers shift right so the
  // cell always sees the current bit at position 0; difference bits enter
  // the working register at the MSB so after N shifts it is LSB-aligned.
  // On the last bit the result is assembled directly from the cell output
  // to avoid an extra cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      w_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      aMsb_q  <= 1'b0;
      bMsb_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            sa_q   <= a;
            sb_q   <= b;
            br_q   <= bin;
            cnt_q  <= '0;
            w_q    <= '0;
            aMsb_q <= a[N-1];
            bMsb_q <= b[N-1];
          end
        end
        RUN: begin
          sa_q  <= {1'b0, sa_q[N-1:1]};
          sb_q  <= {1'b0, sb_q[N-1:1]};
          w_q   <= {bitD, w_q[N-1:1]};
          br_q  <= bitBo;
          cnt_q <= cnt_q + 1'b1;
          if (lastBit) begin
            diff_q <= {bitD, w_q[N-1:1]};
            bout_q <= bitBo;
            // Signed overflow only possible when operand signs differ and
            // the result sign disagrees with the minuend.
            ovf_q  <= (aMsb_q != bMsb_q) && (bitD != aMsb_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_n_bit_serial_sub.sv
// Self-checking bench for n_bit_serial_sub (N=4): directed vectors with
// hand-computed results, handshake/reset corner cases, and a full sweep of
// all 512 operand combinations against an integer reference.
module tb_n_bit_serial_sub;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] a, b;
  logic         bin;
  logic         busy, done;
  logic [N-1:0] diff;
  logic         bout, ovf;

  typedef struct {
    logic [N-1:0] diff;
    logic         bout;
    logic         ovf;
    int           doneCycle;
  } exp_t;

  exp_t expQ[$];

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  bit rstPulse = 0;
  bit armed    = 0;
  logic [N-1:0] lastDiff;
  logic         lastBout, lastOvf;

  n_bit_serial_sub #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycle++;
    if (rst) rstPulse = 1;
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // Monitor: pops the scoreboard whenever done is presented; between done
  // pulses results must stay put, and a reset must clear everything.
  always @(negedge clk) begin
    if (rstPulse) begin
      rstPulse = 0;
      armed    = 1;
      check("rst_outputs", {busy, done, diff, bout, ovf}, 0);
      lastDiff = '0; lastBout = 1'b0; lastOvf = 1'b0;
    end else if (armed && done === 1'b1) begin
      check("busy_during_done", busy, 0);
      if (expQ.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        check("diff", diff, e.diff);
        check("bout", bout, e.bout);
        check("ovf", ovf, e.ovf);
        check("done_cycle", cycle, e.doneCycle);
      end
      lastDiff = diff; lastBout = bout; lastOvf = ovf;
    end else if (armed) begin
      if ({diff, bout, ovf} !== {lastDiff, lastBout, lastOvf})
        check("stable", {diff, bout, ovf}, {lastDiff, lastBout, lastOvf});
    end
  end

  function automatic exp_t model(input logic [N-1:0] av, input logic [N-1:0] bv,
                                 input logic bi, input int dc);
    exp_t e;
    int u, s;
    u = int'(av) - int'(bv) - int'(bi);
    s = int'($signed(av)) - int'($signed(bv)) - int'(bi);
    e.diff = u[N-1:0];
    e.bout = (u < 0);
    e.ovf  = (s < -(1 << (N - 1))) || (s > (1 << (N - 1)) - 1);
    e.doneCycle = dc;
    return e;
  endfunction

  // Issue one operation from idle and push its expected result. Returns
  // once the DUT is back in IDLE so the next call is accepted immediately.
  task automatic applyStimulus(input logic [N-1:0] av, input logic [N-1:0] bv,
                               input logic bi, input logic [N-1:0] eDiff,
                               input logic eBout, input logic eOvf);
    exp_t e;
    @(negedge clk);
    start = 1'b1; a = av; b = bv; bin = bi;
    @(posedge clk);
    #1;
    e.diff = eDiff; e.bout = eBout; e.ovf = eOvf; e.doneCycle = cycle + N;
    expQ.push_back(e);
    start = 1'b0;
    a = ~av; b = ~bv; bin = ~bi;
    check("busy_after_accept", busy, 1);
    repeat (N + 1) @(posedge clk);
  endtask

  task automatic checkOutput();
    int guard = 0;
    while (expQ.size() != 0 && guard < 50) begin
      @(posedge clk);
      guard++;
    end
    if (expQ.size() != 0) check("pending_results", expQ.size(), 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    exp_t e1, e2;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Directed vectors
    applyStimulus(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0);
    applyStimulus(4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b0);
    applyStimulus(4'b0010, 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b1000, 4'b0111, 1'b1, 4'b0000, 1'b0, 1'b1);
    applyStimulus(4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b1, 1'b1);
    applyStimulus(4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b0);
    checkOutput();

    // start held high through RUN and DONE with different operands
    @(negedge clk);
    start = 1'b1; a = 4'b0110; b = 4'b0001; bin = 1'b0;
    @(posedge clk);
    #1;
    e1.diff = 4'b0101; e1.bout = 1'b0; e1.ovf = 1'b0; e1.doneCycle = cycle + N;
    expQ.push_back(e1);
    a = 4'b0011; b = 4'b0101; bin = 1'b1;
    repeat (N + 2) @(posedge clk);
    #1;
    e2.diff = 4'b1101; e2.bout = 1'b1; e2.ovf = 1'b0; e2.doneCycle = cycle + N;
    expQ.push_back(e2);
    start = 1'b0;
    check("done_spacing", e2.doneCycle - e1.doneCycle, N + 2);
    repeat (N + 1) @(posedge clk);
    checkOutput();

    // Reset during the second RUN cycle aborts the operation
    @(negedge clk);
    start = 1'b1; a = 4'b1111; b = 4'b0001; bin = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (N + 3) @(posedge clk);
    applyStimulus(4'b1001, 4'b0100, 1'b0, 4'b0101, 1'b0, 1'b1);
    checkOutput();

    // Sweep every (a, b, bin) combination with random idle gaps
    for (int i = 0; i < 512; i++) begin
      logic [N-1:0] av, bv;
      logic bi;
      exp_t m;
      av = i[8:5]; bv = i[4:1]; bi = i[0];
      m = model(av, bv, bi, 0);
      applyStimulus(av, bv, bi, m.diff, m.bout, m.ovf);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    checkOutput();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
